// File: rtl/bcd_val_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM encoding,
// BCD digit constants and a digit validity helper.
package bcd_val_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ_SUB    = 4'd3;

  // A packed nibble is a legal decimal digit only for 0..9.
  function automatic logic digit_invalid(input logic [3:0] d);
    return (d > BCD_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_val_if.sv
// Request/result bundle for bcd_val: the requester holds en with the
// operand until rdy, and the converter returns count/err.
interface bcd_val_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  en;
  logic [4*DIGITS-1:0]   BCD;
  logic                  rdy;
  logic                  busy;
  logic                  err;
  logic [BIN_W-1:0]      count;

  modport master (output en, BCD, input rdy, busy, err, count);
  modport slave  (input en, BCD, output rdy, busy, err, count);
endinterface

// File: rtl/bcd_val_digit_adj.sv
// One digit of the reverse double-dabble correction: after the right
// shift, a digit that reads 8..15 has borrowed a half-weight bit and is
// brought back into range by subtracting 3. Digits below 8 pass through.
module bcd_val_digit_adj
  import bcd_val_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= BCD_ADJ_THRESH) ? (din - BCD_ADJ_SUB) : din;

endmodule

// File: rtl/bcd_val.sv
// Sequential BCD-to-binary converter (reverse double-dabble). The operand
// is captured on an accepted request, validated, then shifted right one
// bit per cycle through {bcd_reg, bin_reg}; after 4*DIGITS shifts bin_reg
// holds the binary value and bcd_reg has drained to zero.
module bcd_val
  import bcd_val_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic     clk,
  input  logic     reset,
  bcd_val_if.slave bus
);

  localparam int NBITS  = 4 * DIGITS;
  localparam int SHIFTS = 4 * DIGITS;
  localparam int ITER_W = $clog2(SHIFTS + 1);

  state_t              state, state_nx;
  logic [NBITS-1:0]    bcd_reg;
  logic [NBITS-1:0]    bin_reg;
  logic [ITER_W-1:0]   iter;
  logic                err_q;
  logic [BIN_W-1:0]    count_q;

  logic [NBITS-1:0]    bcd_shift;
  logic [NBITS-1:0]    bcd_next;
  logic [NBITS-1:0]    bin_next;
  logic                any_bad;
  logic                last_shift;

  // One shift step: move the whole {bcd, bin} pair right by one bit.
  always_comb begin
    {bcd_shift, bin_next} = {bcd_reg, bin_reg} >> 1;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_val_digit_adj u_adj (
      .din  (bcd_shift[4*g +: 4]),
      .dout (bcd_next[4*g +: 4])
    );
  end

  // Flag an operand containing any nibble outside 0..9.
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_invalid(bcd_reg[4*i +: 4])) any_bad = 1'b1;
    end
  end

  assign last_shift = (iter == ITER_W'(SHIFTS - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; DONE is left only once the requester drops en.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.en) state_nx = LOAD;
      LOAD:    state_nx = any_bad ? DONE : SHIFT;
      SHIFT:   if (last_shift) state_nx = DONE;
      DONE:    if (!bus.en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture, validate, shift/correct and latch the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_reg <= '0;
      bin_reg <= '0;
      iter    <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en) begin
            bcd_reg <= bus.BCD;
            bin_reg <= '0;
          end
        end
        LOAD: begin
          if (any_bad) begin
            err_q   <= 1'b1;
            count_q <= '0;
          end else begin
            err_q <= 1'b0;
            iter  <= '0;
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_next;
          bin_reg <= bin_next;
          iter    <= iter + 1'b1;
          if (last_shift) count_q <= bin_next[BIN_W-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.rdy   = (state == DONE);
  assign bus.busy  = (state != IDLE);
  assign bus.err   = err_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_bcd_val.sv
// Directed bench for bcd_val: hand-computed operands, latencies counted
// in clock edges from the accepting edge (edge 1).
module tb_bcd_val;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   n;

  bcd_val_if #(.DIGITS(4), .BIN_W(14)) bus ();

  bcd_val #(.DIGITS(4), .BIN_W(14)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise en with an operand and count edges until rdy (bounded).
  task automatic run_req(input logic [15:0] v, output int edges);
    bus.BCD = v;
    bus.en  = 1'b1;
    edges   = 0;
    do begin
      tick();
      edges++;
    end while (!bus.rdy && edges < 40);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    bus.en   = 1'b0;
    bus.BCD  = '0;
    #12 reset = 1'b0;

    // Reset state
    check("rst_rdy",   bus.rdy,   0);
    check("rst_busy",  bus.busy,  0);
    check("rst_err",   bus.err,   0);
    check("rst_count", bus.count, 0);
    tick();

    // 1: all nines, en held across DONE
    bus.BCD = 16'h9999;
    bus.en  = 1'b1;
    tick();
    check("t1_busy_early", bus.busy, 1);
    n = 1;
    do begin
      tick();
      n++;
    end while (!bus.rdy && n < 40);
    check("t1_latency", n, 18);
    check("t1_count", bus.count, 9999);
    check("t1_err", bus.err, 0);
    tick();
    check("t1_rdy_held", bus.rdy, 1);
    bus.en = 1'b0;
    tick();
    check("t1_rdy_drop", bus.rdy, 0);
    check("t1_busy_drop", bus.busy, 0);

    // 2: zero operand
    run_req(16'h0000, n);
    check("t2_latency", n, 18);
    check("t2_count", bus.count, 0);
    check("t2_err", bus.err, 0);
    bus.en = 1'b0;
    tick();
    check("t2_rdy_drop", bus.rdy, 0);

    // 3: illegal digit takes the short error path
    run_req(16'h12A4, n);
    check("t3_latency", n, 2);
    check("t3_err", bus.err, 1);
    check("t3_count", bus.count, 0);
    check("t3_rdy", bus.rdy, 1);
    bus.en = 1'b0;
    tick();
    check("t3_idle", bus.busy, 0);

    // 4: one-cycle request, operand disturbed mid-conversion
    bus.BCD = 16'h0042;
    bus.en  = 1'b1;
    tick();
    bus.en = 1'b0;
    n = 1;
    do begin
      tick();
      n++;
      if (n == 6) bus.BCD = 16'h7777;
    end while (!bus.rdy && n < 40);
    check("t4_latency", n, 18);
    check("t4_count", bus.count, 42);
    check("t4_err", bus.err, 0);
    tick();
    check("t4_pulse", bus.rdy, 0);
    check("t4_idle", bus.busy, 0);
    check("t4_count_hold", bus.count, 42);

    // 5: async reset in the middle of shifting
    bus.BCD = 16'h3333;
    bus.en  = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("t5_busy_pre", bus.busy, 1);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_rdy",   bus.rdy,   0);
    check("t5_rst_busy",  bus.busy,  0);
    check("t5_rst_err",   bus.err,   0);
    check("t5_rst_count", bus.count, 0);
    #2;
    reset  = 1'b0;
    bus.en = 1'b0;
    tick();
    run_req(16'h0255, n);
    check("t5_latency", n, 18);
    check("t5_count", bus.count, 255);
    bus.en = 1'b0;
    tick();

    // 6: back-to-back requests separated by one en-low edge
    run_req(16'h1234, n);
    check("t6a_latency", n, 18);
    check("t6a_count", bus.count, 1234);
    bus.en = 1'b0;
    tick();
    bus.BCD = 16'h0500;
    bus.en  = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("t6_count_hold", bus.count, 1234);
    n = 10;
    do begin
      tick();
      n++;
    end while (!bus.rdy && n < 40);
    check("t6b_latency", n, 18);
    check("t6b_count", bus.count, 500);
    check("t6b_err", bus.err, 0);
    bus.en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
